// File: rtl/hamming_pkg.sv
// Shared helpers for the Hamming SEC / SECDED decoder family.
// Build option: define HAMMING_SECDED_EN to append an overall-parity bit to
// the codeword and enable double-error detection.
package hamming_pkg;

`ifdef HAMMING_SECDED_EN
    localparam int SECDED_W = 1;
`else
    localparam int SECDED_W = 0;
`endif

    // True when PAR_W parity bits can address every position plus "no error".
    function automatic bit par_w_ok(input int data_w, input int par_w);
        return (32'sd1 <<< par_w) >= (data_w + par_w + 32'sd1);
    endfunction

    // True when Hamming position p is a parity position (power of two).
    function automatic bit is_pow2(input int p);
        return (p > 32'sd0) && ((p & (p - 32'sd1)) == 32'sd0);
    endfunction

    // Codeword bit index (position - 1) holding data bit i; data fills the
    // non-power-of-two positions in ascending order, LSB first.
    function automatic int data_bit_idx(input int i);
        int cnt;
        int idx;
        bit found;
        cnt   = 32'sd0;
        idx   = 32'sd0;
        found = 1'b0;
        for (int p = 1; p < 256; p++) begin
            if (!found && !is_pow2(p)) begin
                if (cnt == i) begin
                    idx   = p - 32'sd1;
                    found = 1'b1;
                end else begin
                    cnt = cnt + 32'sd1;
                end
            end else begin
                cnt = cnt;
            end
        end
        return idx;
    endfunction

    // Total received codeword width, including the optional overall parity bit.
    function automatic int cw_width(input int data_w, input int par_w);
        return data_w + par_w + SECDED_W;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and overall parity of a codeword.
// Shared by the decoder and the encoder-side checker.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PAR_W  = 4,
    parameter int CW     = cw_width(DATA_W, PAR_W)
) (
    input  logic [CW-1:0]    code,
    output logic [PAR_W-1:0] syn,
    output logic             op
);

    localparam int N = DATA_W + PAR_W;

    // XOR of the Hamming positions of every set bit in positions 1..N.
    function automatic logic [PAR_W-1:0] calc_syn(input logic [CW-1:0] c);
        logic [PAR_W-1:0] s;
        s = {PAR_W{1'b0}};
        for (int p = 1; p <= N; p++) begin
            if (c[p-1]) begin
                s = s ^ PAR_W'(p);
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    // Even parity over the whole codeword (overall parity bit included).
    function automatic logic calc_op(input logic [CW-1:0] c);
        return ^c;
    endfunction

    // Evaluate both checks on the incoming codeword.
    always_comb begin
        syn = calc_syn(code);
        op  = calc_op(code);
    end

endmodule

// File: rtl/hamming_secded_dec.sv
// Pipelined streaming Hamming decoder: S1 captures the codeword with its
// syndrome, S2 registers corrected data and flags. Saturating counters track
// corrected and uncorrectable words on the output handshake.
// Build option: HAMMING_SECDED_EN adds the overall-parity bit and
// double-error detection; without it the decoder is single-error-correct only.
module hamming_secded_dec
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int PAR_W  = 4,
    parameter  int CNT_W  = 16,
    localparam int N      = DATA_W + PAR_W,
    localparam int CW     = cw_width(DATA_W, PAR_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_corrected,
    output logic              out_uncorrectable,
    output logic [CNT_W-1:0]  err_corr_cnt,
    output logic [CNT_W-1:0]  err_uncorr_cnt,
    input  logic              cnt_clr
);

    if (!par_w_ok(DATA_W, PAR_W)) begin : g_bad_par_w
        $error("hamming_secded_dec: PAR_W too small for DATA_W");
    end

    localparam logic [PAR_W-1:0] SYN_ZERO = {PAR_W{1'b0}};
    localparam logic [PAR_W-1:0] N_SYN    = PAR_W'(N);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [PAR_W-1:0]  in_syn_s;
    logic              in_op_s;
    logic              s1_load_s;
    logic              s2_load_s;
    logic              s1_valid_r;
    logic [N-1:0]      s1_code_r;
    logic [PAR_W-1:0]  s1_syn_r;
`ifdef HAMMING_SECDED_EN
    logic              s1_op_r;
`else
    logic              op_unused_s;
    assign op_unused_s = in_op_s;
`endif
    logic              flip_s;
    logic              corr_s;
    logic              unc_s;
    logic [N-1:0]      fixed_s;
    logic [DATA_W-1:0] data_s;
    logic              s2_valid_r;
    logic [DATA_W-1:0] s2_data_r;
    logic [PAR_W-1:0]  s2_syn_r;
    logic              s2_corr_r;
    logic              s2_unc_r;
    logic [CNT_W-1:0]  corr_cnt_r;
    logic [CNT_W-1:0]  unc_cnt_r;
    logic              out_hs_s;

    hamming_syndrome #(
        .DATA_W (DATA_W),
        .PAR_W  (PAR_W),
        .CW     (CW)
    ) u_syndrome (
        .code (in_code),
        .syn  (in_syn_s),
        .op   (in_op_s)
    );

    // A stage may load when it is empty or its content moves on this cycle.
    assign s2_load_s = !s2_valid_r || out_ready;
    assign s1_load_s = !s1_valid_r || s2_load_s;
    assign in_ready  = s1_load_s;
    assign out_hs_s  = s2_valid_r && out_ready;

    // S1: capture the Hamming part of the codeword with its syndrome.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_code_r  <= {N{1'b0}};
            s1_syn_r   <= SYN_ZERO;
`ifdef HAMMING_SECDED_EN
            s1_op_r    <= 1'b0;
`endif
        end else if (s1_load_s) begin
            s1_valid_r <= in_valid;
            s1_code_r  <= in_code[N-1:0];
            s1_syn_r   <= in_syn_s;
`ifdef HAMMING_SECDED_EN
            s1_op_r    <= in_op_s;
`endif
        end else begin
            s1_valid_r <= s1_valid_r;
            s1_code_r  <= s1_code_r;
            s1_syn_r   <= s1_syn_r;
`ifdef HAMMING_SECDED_EN
            s1_op_r    <= s1_op_r;
`endif
        end
    end

    // Classify the word from its syndrome (and overall parity when present).
    always_comb begin
        flip_s = 1'b0;
        corr_s = 1'b0;
        unc_s  = 1'b0;
`ifdef HAMMING_SECDED_EN
        if (s1_syn_r == SYN_ZERO) begin
            // Only the overall parity bit itself can be wrong here.
            corr_s = s1_op_r;
        end else if (s1_op_r) begin
            if (s1_syn_r <= N_SYN) begin
                flip_s = 1'b1;
                corr_s = 1'b1;
            end else begin
                unc_s = 1'b1;
            end
        end else begin
            // Non-zero syndrome with even overall parity: double error.
            unc_s = 1'b1;
        end
`else
        if (s1_syn_r == SYN_ZERO) begin
            corr_s = 1'b0;
        end else if (s1_syn_r <= N_SYN) begin
            flip_s = 1'b1;
            corr_s = 1'b1;
        end else begin
            unc_s = 1'b1;
        end
`endif
    end

    // Flip the bit at the syndrome position when a correction applies.
    always_comb begin
        fixed_s = s1_code_r;
        for (int p = 1; p <= N; p++) begin
            fixed_s[p-1] = s1_code_r[p-1] ^ (flip_s && (s1_syn_r == PAR_W'(p)));
        end
    end

    for (genvar i = 0; i < DATA_W; i++) begin : g_extract
        assign data_s[i] = fixed_s[data_bit_idx(i)];
    end

    // S2: register corrected payload and flags; hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= {DATA_W{1'b0}};
            s2_syn_r   <= SYN_ZERO;
            s2_corr_r  <= 1'b0;
            s2_unc_r   <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            s2_data_r  <= data_s;
            s2_syn_r   <= s1_syn_r;
            s2_corr_r  <= corr_s;
            s2_unc_r   <= unc_s;
        end else begin
            s2_valid_r <= s2_valid_r;
            s2_data_r  <= s2_data_r;
            s2_syn_r   <= s2_syn_r;
            s2_corr_r  <= s2_corr_r;
            s2_unc_r   <= s2_unc_r;
        end
    end

    // Saturating error counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            corr_cnt_r <= {CNT_W{1'b0}};
            unc_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (out_hs_s && s2_corr_r && (corr_cnt_r != CNT_MAX)) begin
                corr_cnt_r <= corr_cnt_r + CNT_ONE;
            end else begin
                corr_cnt_r <= corr_cnt_r;
            end
            if (out_hs_s && s2_unc_r && (unc_cnt_r != CNT_MAX)) begin
                unc_cnt_r <= unc_cnt_r + CNT_ONE;
            end else begin
                unc_cnt_r <= unc_cnt_r;
            end
        end
    end

    assign out_valid         = s2_valid_r;
    assign out_data          = s2_data_r;
    assign out_syndrome      = s2_syn_r;
    assign out_corrected     = s2_corr_r;
    assign out_uncorrectable = s2_unc_r;
    assign err_corr_cnt      = corr_cnt_r;
    assign err_uncorr_cnt    = unc_cnt_r;

endmodule
